// File: rtl/display_pattern_mux.sv
// Stream stage in front of the LVDS display: forwards DMA pixel words or replaces
// them with a generated test pattern, switching modes only at frame boundaries.
module display_pattern_mux #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BAR_W    = H_ACTIVE / 8
) (
    input  logic        lvds_slowclk,
    input  logic        rst_n,
    input  logic [1:0]  cfg_mode,
    input  logic [63:0] s_dma_rdata,
    input  logic        s_dma_rvalid,
    input  logic [7:0]  s_dma_rkeep,
    output logic        s_dma_rready,
    output logic [63:0] m_rdata,
    output logic        m_rvalid,
    output logic [7:0]  m_rkeep,
    input  logic        m_rready,
    output logic [1:0]  active_mode,
    output logic [15:0] frame_count,
    output logic [31:0] debug_partial_count
);

    localparam int WPL       = H_ACTIVE / 2;
    localparam int XW        = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int YW        = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BAR_WORDS = BAR_W / 2;
    localparam int BW        = (BAR_WORDS > 1) ? $clog2(BAR_WORDS) : 1;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    // Two pixels {B,G,R} into one display word, unused bytes zero
    function automatic logic [63:0] pack_pixels(input logic [23:0] px0, input logic [23:0] px1);
        return {8'h00, px1, 8'h00, px0};
    endfunction

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    mode_e         active_mode_q, active_mode_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [31:0]   partial_q, partial_d;
    logic [63:0]   m_rdata_q, m_rdata_d;
    logic [7:0]    m_rkeep_q, m_rkeep_d;
    logic          m_rvalid_q, m_rvalid_d;

    logic          load_s;
    logic          at_origin_s;
    mode_e         eff_mode_s;
    logic          pass_s;
    logic          wr_s;
    logic          adv_s;
    logic [7:0]    word_keep_s;
    logic          x_last_s;
    logic          y_last_s;
    logic [6:0]    x7_s;
    logic [7:0]    y8_s;
    logic [7:0]    p0_s;
    logic [7:0]    p1_s;
    logic [23:0]   bar_px_s;
    logic [63:0]   pattern_s;

    assign load_s       = ~m_rvalid_q | m_rready;
    assign at_origin_s  = (x_q == '0) && (y_q == '0);
    assign eff_mode_s   = at_origin_s ? mode_e'(cfg_mode) : active_mode_q;
    assign pass_s       = (eff_mode_s == MODE_PASS);
    assign wr_s         = load_s & (pass_s ? s_dma_rvalid : 1'b1);
    assign word_keep_s  = pass_s ? s_dma_rkeep : 8'hFF;
    assign adv_s        = wr_s & (word_keep_s == 8'hFF);
    assign s_dma_rready = load_s & pass_s;
    assign x_last_s     = (x_q == XW'(WPL - 1));
    assign y_last_s     = (y_q == YW'(V_ACTIVE - 1));

    // Only the low bits of the position feed the pattern generators
    assign x7_s     = 7'(x_q);
    assign y8_s     = 8'(y_q);
    assign p0_s     = {x7_s, 1'b0};
    assign p1_s     = {x7_s, 1'b1};
    assign bar_px_s = {{8{~bar_idx_q[0]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[1]}}};

    // Pattern word for the current position and effective mode
    always_comb begin
        pattern_s = 64'h0;
        case (eff_mode_s)
            MODE_BARS:  pattern_s = pack_pixels(bar_px_s, bar_px_s);
            MODE_GRAD:  pattern_s = pack_pixels({frame_cnt_q[7:0], y8_s, p0_s},
                                                {frame_cnt_q[7:0], y8_s, p1_s});
            MODE_CHECK: pattern_s = (x7_s[4] ^ y8_s[5]) ? pack_pixels(24'hFFFFFF, 24'hFFFFFF)
                                                        : 64'h0;
            default:    pattern_s = 64'h0;
        endcase
    end

    // Next-state for output register, position, bar tracker and counters
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        bar_cnt_d     = bar_cnt_q;
        bar_idx_d     = bar_idx_q;
        active_mode_d = active_mode_q;
        frame_cnt_d   = frame_cnt_q;
        partial_d     = partial_q;
        m_rdata_d     = m_rdata_q;
        m_rkeep_d     = m_rkeep_q;
        m_rvalid_d    = m_rvalid_q;

        if (at_origin_s) begin
            active_mode_d = eff_mode_s;
        end else begin
            active_mode_d = active_mode_q;
        end

        if (load_s) begin
            m_rvalid_d = wr_s;
        end else begin
            m_rvalid_d = m_rvalid_q;
        end

        if (wr_s) begin
            m_rdata_d = pass_s ? s_dma_rdata : pattern_s;
            m_rkeep_d = word_keep_s;
        end else begin
            m_rdata_d = m_rdata_q;
            m_rkeep_d = m_rkeep_q;
        end

        if (wr_s && pass_s && (s_dma_rkeep != 8'hFF) && (partial_q != 32'hFFFF_FFFF)) begin
            partial_d = partial_q + 32'd1;
        end else begin
            partial_d = partial_q;
        end

        // Bar tracker follows x so the colour bars never need a divider
        if (adv_s) begin
            if (x_last_s) begin
                x_d       = '0;
                bar_cnt_d = '0;
                bar_idx_d = 3'd0;
                if (y_last_s) begin
                    y_d         = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
                if (bar_cnt_q == BW'(BAR_WORDS - 1)) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + BW'(1);
                end
            end
        end else begin
            x_d = x_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge lvds_slowclk) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= 3'd0;
            active_mode_q <= MODE_PASS;
            frame_cnt_q   <= 16'd0;
            partial_q     <= 32'd0;
            m_rdata_q     <= 64'h0;
            m_rkeep_q     <= 8'h00;
            m_rvalid_q    <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
            active_mode_q <= active_mode_d;
            frame_cnt_q   <= frame_cnt_d;
            partial_q     <= partial_d;
            m_rdata_q     <= m_rdata_d;
            m_rkeep_q     <= m_rkeep_d;
            m_rvalid_q    <= m_rvalid_d;
        end
    end

    assign m_rdata             = m_rdata_q;
    assign m_rkeep             = m_rkeep_q;
    assign m_rvalid            = m_rvalid_q;
    assign active_mode         = active_mode_q;
    assign frame_count         = frame_cnt_q;
    assign debug_partial_count = partial_q;

endmodule

// File: tb/tb_display_pattern_mux.sv
// Directed bench for display_pattern_mux on a reduced 64x40 frame so whole
// frames fit in a short run.
module tb_display_pattern_mux;

    localparam int H     = 64;
    localparam int V     = 40;
    localparam int WPL   = H / 2;
    localparam int WPF   = WPL * V;
    localparam int BAR_W = H / 8;

    logic        lvds_slowclk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic [63:0] s_dma_rdata;
    logic        s_dma_rvalid;
    logic [7:0]  s_dma_rkeep;
    logic        s_dma_rready;
    logic [63:0] m_rdata;
    logic        m_rvalid;
    logic [7:0]  m_rkeep;
    logic        m_rready;
    logic [1:0]  active_mode;
    logic [15:0] frame_count;
    logic [31:0] debug_partial_count;

    int errors = 0;
    int checks = 0;

    always #5 lvds_slowclk = ~lvds_slowclk;

    display_pattern_mux #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .lvds_slowclk        (lvds_slowclk),
        .rst_n               (rst_n),
        .cfg_mode            (cfg_mode),
        .s_dma_rdata         (s_dma_rdata),
        .s_dma_rvalid        (s_dma_rvalid),
        .s_dma_rkeep         (s_dma_rkeep),
        .s_dma_rready        (s_dma_rready),
        .m_rdata             (m_rdata),
        .m_rvalid            (m_rvalid),
        .m_rkeep             (m_rkeep),
        .m_rready            (m_rready),
        .active_mode         (active_mode),
        .frame_count         (frame_count),
        .debug_partial_count (debug_partial_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge lvds_slowclk);
        #1;
    endtask

    function automatic logic [63:0] pack2(input logic [23:0] px0, input logic [23:0] px1);
        return {8'h00, px1, 8'h00, px0};
    endfunction

    function automatic logic [63:0] bars_word(input int x);
        int i;
        logic [7:0] r, g, b;
        i = (2 * x) / BAR_W;
        r = ((i >> 1) & 1) != 0 ? 8'h00 : 8'hFF;
        g = ((i >> 2) & 1) != 0 ? 8'h00 : 8'hFF;
        b = (i & 1) != 0 ? 8'h00 : 8'hFF;
        return pack2({b, g, r}, {b, g, r});
    endfunction

    function automatic logic [63:0] grad_word(input int x, input int y, input int fc);
        logic [7:0] a, c, yy, f;
        a  = 8'(2 * x);
        c  = 8'(2 * x + 1);
        yy = 8'(y);
        f  = 8'(fc);
        return pack2({f, yy, a}, {f, yy, c});
    endfunction

    function automatic logic [63:0] chk_word(input int x, input int y);
        if ((((x >> 4) ^ (y >> 5)) & 1) != 0) return pack2(24'hFFFFFF, 24'hFFFFFF);
        return 64'h0;
    endfunction

    initial begin
        int n;
        int cyc;
        logic pv, pr;
        logic [63:0] pd, exp_w;

        rst_n = 1'b0;
        cfg_mode = 2'd1;
        s_dma_rdata = 64'h0;
        s_dma_rvalid = 1'b0;
        s_dma_rkeep = 8'h00;
        m_rready = 1'b0;
        repeat (3) tick();

        check_eq("rst_rvalid", 64'(m_rvalid), 64'd0);
        check_eq("rst_rdata", m_rdata, 64'd0);
        check_eq("rst_rkeep", 64'(m_rkeep), 64'd0);
        check_eq("rst_active_mode", 64'(active_mode), 64'd0);
        check_eq("rst_frame_count", 64'(frame_count), 64'd0);
        check_eq("rst_partial", 64'(debug_partial_count), 64'd0);
        check_eq("rst_rready_pattern", 64'(s_dma_rready), 64'd0);
        cfg_mode = 2'd0;
        #1;
        check_eq("rst_rready_pass", 64'(s_dma_rready), 64'd1);
        cfg_mode = 2'd1;

        // Colour bars frame
        m_rready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < WPF; k++) begin
            tick();
            check_eq("bars_word", m_rdata, bars_word(k % WPL));
            if (k == 0) begin
                check_eq("bars_first_white", m_rdata, 64'h00FFFFFF00FFFFFF);
                check_eq("bars_first_keep", 64'(m_rkeep), 64'hFF);
                check_eq("bars_active_mode", 64'(active_mode), 64'd1);
            end
            if (k == 4) check_eq("bars_yellow", m_rdata, 64'h0000FFFF0000FFFF);
            if (k == WPL) check_eq("bars_line1_white", m_rdata, 64'h00FFFFFF00FFFFFF);
        end
        check_eq("bars_frame_count", 64'(frame_count), 64'd1);

        // Passthrough frame with one partial word inserted
        cfg_mode = 2'd0;
        s_dma_rvalid = 1'b1;
        for (int k = 0; k <= WPF; k++) begin
            s_dma_rdata = {32'(k), ~32'(k)};
            s_dma_rkeep = (k == 500) ? 8'h0F : 8'hFF;
            #1;
            check_eq("pass_rready", 64'(s_dma_rready), 64'd1);
            tick();
            check_eq("pass_data", m_rdata, {32'(k), ~32'(k)});
            check_eq("pass_keep", 64'(m_rkeep), (k == 500) ? 64'h0F : 64'hFF);
            if (k == WPF - 1) check_eq("pass_fc_not_yet", 64'(frame_count), 64'd1);
        end
        check_eq("pass_frame_count", 64'(frame_count), 64'd2);
        check_eq("pass_partial", 64'(debug_partial_count), 64'd1);
        s_dma_rvalid = 1'b0;
        tick();
        check_eq("pass_idle_rvalid", 64'(m_rvalid), 64'd0);

        // Passthrough frame with a mid-frame request for gradient
        s_dma_rvalid = 1'b1;
        s_dma_rkeep = 8'hFF;
        for (int k = 0; k < WPF; k++) begin
            s_dma_rdata = {32'h5A5A0000 | 32'(k), 32'(k)};
            if (k == 5 * WPL + 10) cfg_mode = 2'd2;
            #1;
            check_eq("sw_rready", 64'(s_dma_rready), 64'd1);
            tick();
            check_eq("sw_data", m_rdata, {32'h5A5A0000 | 32'(k), 32'(k)});
            if (k >= 5 * WPL + 10) check_eq("sw_active_hold", 64'(active_mode), 64'd0);
        end
        check_eq("sw_frame_count", 64'(frame_count), 64'd3);
        check_eq("sw_boundary_rready", 64'(s_dma_rready), 64'd0);
        tick();
        check_eq("grad_first", m_rdata, 64'h0003000100030000);
        check_eq("grad_active_mode", 64'(active_mode), 64'd2);

        // Rest of the gradient frame; a mid-frame request for checkerboard waits
        for (int k = 1; k < WPF; k++) begin
            if (k == 1) cfg_mode = 2'd3;
            #1;
            check_eq("grad_rready", 64'(s_dma_rready), 64'd0);
            tick();
            check_eq("grad_word", m_rdata, grad_word(k % WPL, k / WPL, 3));
        end
        check_eq("grad_frame_count", 64'(frame_count), 64'd4);
        check_eq("chk_boundary_rready", 64'(s_dma_rready), 64'd0);

        // Checkerboard frame with random backpressure
        n = -1;
        cyc = 0;
        pv = 1'b0;
        pr = 1'b0;
        pd = 64'h0;
        while (n < WPF && cyc < 6000) begin
            m_rready = 1'($urandom_range(0, 1));
            #1;
            if (pv && !pr) begin
                check_eq("stall_valid", 64'(m_rvalid), 64'd1);
                check_eq("stall_data", m_rdata, pd);
            end
            if (m_rvalid && m_rready) begin
                exp_w = (n < 0) ? grad_word(WPL - 1, V - 1, 3) : chk_word(n % WPL, n / WPL);
                check_eq("chk_word", m_rdata, exp_w);
                if (n == 16) check_eq("chk_x16_y0_white", m_rdata, 64'h00FFFFFF00FFFFFF);
                if (n == 32 * WPL + 16) check_eq("chk_x16_y32_black", m_rdata, 64'h0);
                n++;
            end
            pv = m_rvalid;
            pr = m_rready;
            pd = m_rdata;
            tick();
            cyc++;
        end
        if (n < WPF) check_eq("chk_timeout", 64'(n), 64'(WPF));
        check_eq("chk_frame_count", 64'(frame_count), 64'd5);
        check_eq("chk_partial_kept", 64'(debug_partial_count), 64'd1);

        // Gradient after a clean reset, then reset mid-frame
        cfg_mode = 2'd2;
        m_rready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5 * WPL + 10; k++) begin
            tick();
            check_eq("rgrad_word", m_rdata, grad_word(k % WPL, k / WPL, 0));
        end
        rst_n = 1'b0;
        tick();
        check_eq("mrst_rvalid", 64'(m_rvalid), 64'd0);
        check_eq("mrst_rdata", m_rdata, 64'd0);
        check_eq("mrst_rkeep", 64'(m_rkeep), 64'd0);
        check_eq("mrst_active_mode", 64'(active_mode), 64'd0);
        check_eq("mrst_frame_count", 64'(frame_count), 64'd0);
        check_eq("mrst_partial", 64'(debug_partial_count), 64'd0);
        rst_n = 1'b1;
        #1;
        check_eq("mrst_rready", 64'(s_dma_rready), 64'd0);
        tick();
        check_eq("restart_word0", m_rdata, 64'h0000000100000000);
        check_eq("restart_valid", 64'(m_rvalid), 64'd1);
        check_eq("restart_active_mode", 64'(active_mode), 64'd2);
        tick();
        check_eq("restart_word1", m_rdata, 64'h0000000300000002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
